// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared encodings for the ID-stage branch scheduler: opcodes, REGIMM variants,
// comparator forward selects, FSM states and the branch decode helper.
package branch_resolve_ctrl_pkg;

  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_REGIMM = 6'b000001;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } br_state_t;

  typedef struct packed {
    logic valid;
    logic uses_rt;
    logic link;
  } br_info_t;

  // Unrecognised opcodes/variants come back invalid: never taken, no link, no stall.
  function automatic br_info_t decode_br(input logic [5:0] op, input logic [4:0] rt);
    br_info_t info;
    info = '0;
    case (op)
      OP_BEQ, OP_BNE: begin
        info.valid   = 1'b1;
        info.uses_rt = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: info.valid = 1'b1;
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: info.valid = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin
            info.valid = 1'b1;
            info.link  = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_hazard_detect.sv
// branch_hazard_detect: combinational stall need and comparator forward selects
// for the branch operands currently in ID.
module branch_hazard_detect
  import branch_resolve_ctrl_pkg::*;
(
  input  logic       is_br,
  input  logic       uses_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ex_regwrite,
  input  logic       ex_memtoreg,
  input  logic [4:0] ex_dst,
  input  logic       mem_regwrite,
  input  logic       mem_memtoreg,
  input  logic [4:0] mem_dst,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_dst,
  output logic [1:0] need,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  // An operand that is not read is folded onto $0, which never hazards.
  logic [4:0] ra, rb;
  assign ra = is_br ? rs : 5'd0;
  assign rb = (is_br && uses_rt) ? rt : 5'd0;

  logic [1:0] need_a, need_b;

  always_comb begin
    need_a = 2'd0;
    need_b = 2'd0;
    fwd_a  = FWD_RF;
    fwd_b  = FWD_RF;
    if (ra != 5'd0) begin
      if (ex_regwrite && ex_dst == ra)
        need_a = ex_memtoreg ? 2'd2 : 2'd1;
      else if (mem_regwrite && mem_memtoreg && mem_dst == ra)
        need_a = 2'd1;
      if (mem_regwrite && !mem_memtoreg && mem_dst == ra)
        fwd_a = FWD_MEM;
      else if (wb_regwrite && wb_dst == ra)
        fwd_a = FWD_WB;
    end
    if (rb != 5'd0) begin
      if (ex_regwrite && ex_dst == rb)
        need_b = ex_memtoreg ? 2'd2 : 2'd1;
      else if (mem_regwrite && mem_memtoreg && mem_dst == rb)
        need_b = 2'd1;
      if (mem_regwrite && !mem_memtoreg && mem_dst == rb)
        fwd_b = FWD_MEM;
      else if (wb_regwrite && wb_dst == rb)
        fwd_b = FWD_WB;
    end
  end

  assign need = (need_a > need_b) ? need_a : need_b;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch scheduler: stalls F/D until comparator operands are valid, then
// issues redirect/link. Optional statistics counters under BRANCH_STATS_EN.
//
// state   | meaning
// IDLE    | no branch pending; zero-need branch resolves in the same cycle
// WAIT    | counting down known stall cycles
// RESOLVE | re-check need; resolve when clear, otherwise stall again
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        id_branch_i,
  input  logic [5:0]  id_op_i,
  input  logic [4:0]  id_rt_i,
  input  logic [4:0]  id_rs_i,
  input  logic        ex_regwrite_i,
  input  logic        ex_memtoreg_i,
  input  logic [4:0]  ex_dst_i,
  input  logic        mem_regwrite_i,
  input  logic        mem_memtoreg_i,
  input  logic [4:0]  mem_dst_i,
  input  logic        wb_regwrite_i,
  input  logic [4:0]  wb_dst_i,
  input  logic        cmp_y_i,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic        stall_fd_o,
  output logic        flush_e_o,
  output logic        pc_src_o,
  output logic        link_o,
  output logic [31:0] stat_br_o,
  output logic [31:0] stat_taken_o,
  output logic [31:0] stat_stall_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  br_info_t   info;
  logic       is_br;
  logic [1:0] need, fwd_a, fwd_b;
  br_state_t  state;
  logic [CW-1:0] cnt;
  logic       resolve;

  assign info  = decode_br(id_op_i, id_rt_i);
  assign is_br = id_branch_i & info.valid;

  branch_hazard_detect u_hazard (
    .is_br        (is_br),
    .uses_rt      (info.uses_rt),
    .rs           (id_rs_i),
    .rt           (id_rt_i),
    .ex_regwrite  (ex_regwrite_i),
    .ex_memtoreg  (ex_memtoreg_i),
    .ex_dst       (ex_dst_i),
    .mem_regwrite (mem_regwrite_i),
    .mem_memtoreg (mem_memtoreg_i),
    .mem_dst      (mem_dst_i),
    .wb_regwrite  (wb_regwrite_i),
    .wb_dst       (wb_dst_i),
    .need         (need),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  // Redirect must land in the cycle the comparator result is valid, so outputs are decoded from state.
  always_comb begin
    stall_fd_o = 1'b0;
    flush_e_o  = 1'b0;
    resolve    = 1'b0;
    if (!rst && !flush_i) begin
      case (state)
        ST_IDLE: begin
          if (is_br) begin
            if (need != 2'd0) begin
              stall_fd_o = 1'b1;
              flush_e_o  = 1'b1;
            end else begin
              resolve = 1'b1;
            end
          end
        end
        ST_WAIT: begin
          stall_fd_o = 1'b1;
          flush_e_o  = 1'b1;
        end
        ST_RESOLVE: begin
          if (need != 2'd0) begin
            stall_fd_o = 1'b1;
            flush_e_o  = 1'b1;
          end else if (is_br) begin
            resolve = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_src_o = resolve & cmp_y_i;
  assign link_o   = resolve & info.link;
  assign fwd_a_o  = rst ? FWD_RF : fwd_a;
  assign fwd_b_o  = rst ? FWD_RF : fwd_b;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_br && need != 2'd0) begin
            cnt   <= CW'(need - 2'd1);
            state <= (need > 2'd1) ? ST_WAIT : ST_RESOLVE;
          end
        end
        ST_WAIT: begin
          if (cnt <= CW'(1)) begin
            cnt   <= '0;
            state <= ST_RESOLVE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RESOLVE: begin
          if (need == 2'd0) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] n_br, n_taken, n_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_br    <= '0;
      n_taken <= '0;
      n_stall <= '0;
    end else begin
      if (resolve)    n_br    <= n_br + 32'd1;
      if (pc_src_o)   n_taken <= n_taken + 32'd1;
      if (stall_fd_o) n_stall <= n_stall + 32'd1;
    end
  end

  assign stat_br_o    = rst ? 32'd0 : n_br;
  assign stat_taken_o = rst ? 32'd0 : n_taken;
  assign stat_stall_o = rst ? 32'd0 : n_stall;
`else
  assign stat_br_o    = 32'd0;
  assign stat_taken_o = 32'd0;
  assign stat_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; stat expectations follow BRANCH_STATS_EN.
module tb_branch_resolve_ctrl;

  logic        clk, rst, flush_i, id_branch_i;
  logic [5:0]  id_op_i;
  logic [4:0]  id_rt_i, id_rs_i;
  logic        ex_regwrite_i, ex_memtoreg_i;
  logic [4:0]  ex_dst_i;
  logic        mem_regwrite_i, mem_memtoreg_i;
  logic [4:0]  mem_dst_i;
  logic        wb_regwrite_i;
  logic [4:0]  wb_dst_i;
  logic        cmp_y_i;
  logic [1:0]  fwd_a_o, fwd_b_o;
  logic        stall_fd_o, flush_e_o, pc_src_o, link_o;
  logic [31:0] stat_br_o, stat_taken_o, stat_stall_o;

  int checks = 0;
  int failures = 0;

  // {stall, flush_e, pc_src, link, fwd_a, fwd_b}
  logic [7:0] outv;
  assign outv = {stall_fd_o, flush_e_o, pc_src_o, link_o, fwd_a_o, fwd_b_o};

  branch_resolve_ctrl #(.MAX_WAIT(2)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .id_branch_i(id_branch_i),
    .id_op_i(id_op_i), .id_rt_i(id_rt_i), .id_rs_i(id_rs_i),
    .ex_regwrite_i(ex_regwrite_i), .ex_memtoreg_i(ex_memtoreg_i), .ex_dst_i(ex_dst_i),
    .mem_regwrite_i(mem_regwrite_i), .mem_memtoreg_i(mem_memtoreg_i), .mem_dst_i(mem_dst_i),
    .wb_regwrite_i(wb_regwrite_i), .wb_dst_i(wb_dst_i), .cmp_y_i(cmp_y_i),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_fd_o(stall_fd_o), .flush_e_o(flush_e_o),
    .pc_src_o(pc_src_o), .link_o(link_o),
    .stat_br_o(stat_br_o), .stat_taken_o(stat_taken_o), .stat_stall_o(stat_stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_id(input logic br, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic y);
    id_branch_i = br; id_op_i = op; id_rs_i = rs; id_rt_i = rt; cmp_y_i = y;
  endtask

  task automatic set_pipe(input logic exw, input logic exl, input logic [4:0] exd,
                          input logic mw, input logic ml, input logic [4:0] md,
                          input logic ww, input logic [4:0] wd);
    ex_regwrite_i = exw; ex_memtoreg_i = exl; ex_dst_i = exd;
    mem_regwrite_i = mw; mem_memtoreg_i = ml; mem_dst_i = md;
    wb_regwrite_i = ww; wb_dst_i = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0;
    set_id(1'b1, 6'b000111, 5'd7, 5'd0, 1'b1);
    set_pipe(1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7);
    settle();
    checks++;
    if (outv !== 8'h00) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", outv, 8'h00);
    end
    tick(); tick();
    checks++;
    if ({stat_br_o, stat_taken_o, stat_stall_o} !== 96'd0) begin
      failures++; $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", stat_br_o, stat_taken_o, stat_stall_o);
    end
    rst = 1'b0;
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 1'b0);
    set_pipe(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
  endtask

  // BGTZ on a load result: two stall cycles, then resolve from WB.
  task automatic test_load_use();
    logic [95:0] exp_stats;
    set_id(1'b1, 6'b000111, 5'd7, 5'd0, 1'b1);
    set_pipe(1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    settle();
    checks++;
    if (outv !== 8'b1100_0000) begin failures++; $display("FAIL load_use_c0 got=%b exp=%b", outv, 8'b1100_0000); end
    tick();
    set_pipe(1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0);
    settle();
    checks++;
    if (outv !== 8'b1100_0000) begin failures++; $display("FAIL load_use_c1 got=%b exp=%b", outv, 8'b1100_0000); end
    tick();
    set_pipe(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7);
    settle();
    checks++;
    if (outv !== 8'b0010_1000) begin failures++; $display("FAIL load_use_resolve got=%b exp=%b", outv, 8'b0010_1000); end
    tick();
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 1'b0);
    set_pipe(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    settle();
`ifdef BRANCH_STATS_EN
    exp_stats = {32'd1, 32'd1, 32'd2};
`else
    exp_stats = 96'd0;
`endif
    checks++;
    if ({stat_br_o, stat_taken_o, stat_stall_o} !== exp_stats) begin
      failures++; $display("FAIL load_use_stats got=%0d/%0d/%0d exp=%0d/%0d/%0d", stat_br_o, stat_taken_o,
                           stat_stall_o, exp_stats[95:64], exp_stats[63:32], exp_stats[31:0]);
    end
    tick();
  endtask

  task automatic test_beq_nohaz();
    set_id(1'b1, 6'b000100, 5'd3, 5'd4, 1'b1);
    set_pipe(1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 5'd9, 1'b1, 5'd10);
    settle();
    checks++;
    if (outv !== 8'b0010_0000) begin failures++; $display("FAIL beq_nohaz got=%b exp=%b", outv, 8'b0010_0000); end
    tick();
  endtask

  // BNE after an ALU producer, then a non-branch with the producer still in MEM.
  task automatic test_bne_alu();
    set_id(1'b1, 6'b000101, 5'd5, 5'd6, 1'b1);
    set_pipe(1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    settle();
    checks++;
    if (outv !== 8'b1100_0000) begin failures++; $display("FAIL bne_alu_stall got=%b exp=%b", outv, 8'b1100_0000); end
    tick();
    set_pipe(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0);
    settle();
    checks++;
    if (outv !== 8'b0010_0100) begin failures++; $display("FAIL bne_alu_resolve got=%b exp=%b", outv, 8'b0010_0100); end
    tick();
    set_id(1'b0, 6'b000101, 5'd5, 5'd6, 1'b1);
    settle();
    checks++;
    if (outv !== 8'h00) begin failures++; $display("FAIL non_branch got=%b exp=%b", outv, 8'h00); end
    tick();
  endtask

  task automatic test_rt_operand();
    set_id(1'b1, 6'b000100, 5'd3, 5'd9, 1'b0);
    set_pipe(1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
    settle();
    checks++;
    if (outv !== 8'b1100_0000) begin failures++; $display("FAIL rt_mem_load got=%b exp=%b", outv, 8'b1100_0000); end
    tick();
    set_pipe(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9);
    settle();
    checks++;
    if (outv !== 8'b0000_0010) begin failures++; $display("FAIL rt_wb_resolve got=%b exp=%b", outv, 8'b0000_0010); end
    tick();
  endtask

  task automatic test_restall();
    set_id(1'b1, 6'b000101, 5'd5, 5'd0, 1'b1);
    set_pipe(1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    settle(); tick();
    settle();
    checks++;
    if (outv !== 8'b1100_0000) begin failures++; $display("FAIL restall_hold got=%b exp=%b", outv, 8'b1100_0000); end
    tick();
    set_pipe(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0);
    settle();
    checks++;
    if (outv !== 8'b0010_0100) begin failures++; $display("FAIL restall_resolve got=%b exp=%b", outv, 8'b0010_0100); end
    tick();
  endtask

  // REGIMM variants: rt is a variant code, so producers of $16/$17 must not matter.
  task automatic test_regimm();
    set_pipe(1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 5'd17, 1'b1, 5'd16);
    set_id(1'b1, 6'b000001, 5'd2, 5'b10000, 1'b0);
    settle();
    checks++;
    if (outv !== 8'b0001_0000) begin failures++; $display("FAIL bltzal_nt got=%b exp=%b", outv, 8'b0001_0000); end
    tick();
    set_id(1'b1, 6'b000001, 5'd2, 5'b10001, 1'b1);
    settle();
    checks++;
    if (outv !== 8'b0011_0000) begin failures++; $display("FAIL bgezal_t got=%b exp=%b", outv, 8'b0011_0000); end
    tick();
    set_id(1'b1, 6'b000001, 5'd2, 5'b00001, 1'b1);
    settle();
    checks++;
    if (outv !== 8'b0010_0000) begin failures++; $display("FAIL bgez_t got=%b exp=%b", outv, 8'b0010_0000); end
    tick();
  endtask

  task automatic test_zero_and_unknown();
    set_id(1'b1, 6'b000100, 5'd0, 5'd0, 1'b1);
    set_pipe(1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0);
    settle();
    checks++;
    if (outv !== 8'b0010_0000) begin failures++; $display("FAIL zero_reg got=%b exp=%b", outv, 8'b0010_0000); end
    tick();
    set_id(1'b1, 6'b000010, 5'd7, 5'd0, 1'b1);
    set_pipe(1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    settle();
    checks++;
    if (outv !== 8'h00) begin failures++; $display("FAIL unknown_op got=%b exp=%b", outv, 8'h00); end
    tick();
    set_id(1'b1, 6'b000001, 5'd7, 5'b00011, 1'b1);
    settle();
    checks++;
    if (outv !== 8'h00) begin failures++; $display("FAIL unknown_regimm got=%b exp=%b", outv, 8'h00); end
    tick();
  endtask

  task automatic test_flush();
    set_id(1'b1, 6'b000111, 5'd7, 5'd0, 1'b1);
    set_pipe(1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    settle(); tick();
    flush_i = 1'b1;
    set_pipe(1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0);
    settle();
    checks++;
    if (outv !== 8'h00) begin failures++; $display("FAIL flush_cycle got=%b exp=%b", outv, 8'h00); end
    tick();
    flush_i = 1'b0;
    set_id(1'b1, 6'b000100, 5'd3, 5'd4, 1'b1);
    set_pipe(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    settle();
    checks++;
    if (outv !== 8'b0010_0000) begin failures++; $display("FAIL flush_back_idle got=%b exp=%b", outv, 8'b0010_0000); end
    tick();
    flush_i = 1'b1;
    settle();
    checks++;
    if (outv !== 8'h00) begin failures++; $display("FAIL flush_idle_branch got=%b exp=%b", outv, 8'h00); end
    tick();
    flush_i = 1'b0;
  endtask

  task automatic test_rst_mid_wait();
    set_id(1'b1, 6'b000111, 5'd7, 5'd0, 1'b1);
    set_pipe(1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    settle(); tick();
    rst = 1'b1;
    set_pipe(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 5'd0);
    settle();
    checks++;
    if (outv !== 8'h00) begin failures++; $display("FAIL rst_mid_wait got=%b exp=%b", outv, 8'h00); end
    checks++;
    if ({stat_br_o, stat_taken_o, stat_stall_o} !== 96'd0) begin
      failures++; $display("FAIL rst_mid_wait_stats got=%0d/%0d/%0d exp=0/0/0", stat_br_o, stat_taken_o, stat_stall_o);
    end
    tick();
    rst = 1'b0;
    set_id(1'b1, 6'b000100, 5'd3, 5'd4, 1'b1);
    set_pipe(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    settle();
    checks++;
    if (outv !== 8'b0010_0000) begin failures++; $display("FAIL rst_back_idle got=%b exp=%b", outv, 8'b0010_0000); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_beq_nohaz();
    test_bne_alu();
    test_rt_operand();
    test_restall();
    test_regimm();
    test_zero_and_unknown();
    test_flush();
    test_rst_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- ID-stage branch scheduler for the 5-stage MIPS pipeline.
- Drives the ID-stage branch comparator: selects comparator operand forwarding and stalls F/D until operands are valid.
- Samples the comparator result and issues the PC-redirect and link requests.
- Covers BEQ, BNE, BGTZ, BLEZ, BLTZ, BGEZ, BLTZAL and BGEZAL.

Parameters:
- MAX_WAIT, 2, maximum stall count; the counter width is clog2(MAX_WAIT+1).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  exception/ERET flush; aborts any pending branch
- id_branch_i  in  1  a branch-class instruction is valid in ID
- id_op_i  in  6  ID opcode
- id_rt_i  in  5  rt field; also selects the REGIMM branch variant
- id_rs_i  in  5  rs register address
- ex_regwrite_i  in  1  EX instruction writes the register file
- ex_memtoreg_i  in  1  EX instruction is a load
- ex_dst_i  in  5  EX destination register
- mem_regwrite_i  in  1  MEM instruction writes the register file
- mem_memtoreg_i  in  1  MEM instruction is a load
- mem_dst_i  in  5  MEM destination register
- wb_regwrite_i  in  1  WB instruction writes the register file
- wb_dst_i  in  5  WB destination register
- cmp_y_i  in  1  comparator branch-condition result
- fwd_a_o  out  2  comparator operand-a source: 00 regfile, 01 MEM ALU result, 10 WB result
- fwd_b_o  out  2  comparator operand-b source, same encoding
- stall_fd_o  out  1  hold PC and the IF/ID register
- flush_e_o  out  1  insert a bubble into ID/EX
- pc_src_o  out  1  branch taken; select the branch target
- link_o  out  1  write PC+8 to $31 (AL variants)
- stat_br_o  out  32  resolved-branch count
- stat_taken_o  out  32  taken-branch count
- stat_stall_o  out  32  branch stall-cycle count

Behaviour:
- Operand use:
  - rs is always read.
  - rt is read as a register only for BEQ and BNE.
  - Register $0 never causes a hazard and is never forwarded.
- Stall need, per used operand; the larger value wins:
  - EX non-load producer matching the operand = 1.
  - EX load matching = 2.
  - MEM load matching = 1.
  - Otherwise 0.
- Forwarding, evaluated every cycle with first match winning:
  - MEM non-load match gives 01.
  - WB match gives 10.
  - Otherwise 00.
- FSM states are IDLE, WAIT and RESOLVE.
- IDLE:
  - id_branch_i with need 0 resolves in the same cycle, combinationally: pc_src_o = cmp_y_i, link_o = AL variant.
  - id_branch_i with need N>0 asserts stall_fd_o and flush_e_o, loads cnt=N-1, and moves to WAIT if N-1>0, else to RESOLVE.
- WAIT:
  - stall_fd_o and flush_e_o are asserted and cnt decrements.
  - When cnt==0 the FSM moves to RESOLVE.
- RESOLVE:
  - The need is re-evaluated. If it is still >0 (an upstream bubble did not clear it), the FSM stalls one more cycle and stays in RESOLVE.
  - Otherwise there is no stall: pc_src_o = cmp_y_i, link_o = AL variant, and the FSM returns to IDLE.
- pc_src_o and link_o are combinational in the resolve cycle only and are 0 in every other cycle.
- The delay slot is not squashed by this block.
- AL variants assert link_o whether or not the branch is taken.
- A non-branch instruction in ID in IDLE keeps all outputs 0 and fwd at 00.
- flush_i has priority over everything:
  - It forces IDLE with cnt=0.
  - stall_fd_o, pc_src_o and link_o are 0 in the flush cycle.
  - flush_e_o is 0 in the flush cycle.
- Reset:
  - State goes to IDLE, cnt to 0 and all counters to 0.
  - All outputs are 0 while rst is high.
- Unknown opcode with id_branch_i high is treated as not taken, with no link and no stall.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined:
  - stat_br_o increments on every resolve cycle.
  - stat_taken_o increments on resolve cycles with pc_src_o=1.
  - stat_stall_o increments on every cycle with stall_fd_o=1.
  - Counters wrap at 2^32.
- When undefined, the counters are not synthesized and all stat_* ports are tied to 0.

Decomposition:
- Shared package/defines file holds:
  - Opcode codes: BEQ=000100, BNE=000101, BLEZ=000110, BGTZ=000111, REGIMM_INST=000001.
  - REGIMM rt codes: BLTZ=00000, BGEZ=00001, BLTZAL=10000, BGEZAL=10001.
  - Forward-select encodings and FSM state encodings.
- One natural sub-module: branch_hazard_detect, a combinational block computing the need and the fwd selects.

Test Plan:
- BEQ rs=3, rt=4 with no producers in flight and cmp_y=1 -> same-cycle pc_src_o=1, stall_fd_o=0, fwd=00/00.
- BNE rs=5 with EX ALU writing $5 -> 1 stall cycle; next cycle fwd_a_o=01 (MEM), pc_src_o=cmp_y_i.
- BGTZ rs=7 with EX load writing $7 -> 2 stall cycles; resolve with fwd_a_o=10 (WB); stat_stall_o += 2 when BRANCH_STATS_EN is defined.
- BLTZAL rs=2 with cmp_y=0 -> pc_src_o=0 and link_o=1 in the resolve cycle.
- BEQ rs=0, rt=0 with EX writing $0 -> no stall, fwd=00, resolve at once.
- flush_i during the second stall cycle of a load-use branch -> next cycle IDLE, no pc_src_o pulse; rst mid-WAIT -> all outputs 0.
